// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: sequencer states and grant owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and load/store,
// one access at a time, with a starvation guard that forces a fetch after MAX_STREAK data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT        = 1,
  parameter int ADDR_W     = 10,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam int SW = (MAX_STREAK < 2) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_STREAK);

  state_e              state_q, state_d;
  gnt_e                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                busy_q;
  logic                grant_d;

  // Only the word-address field of the byte addresses reaches the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

  // Data has priority unless it has already starved a waiting fetch MAX_STREAK times.
  assign grant_d = d_req && !(if_req && (streak_q == MAX_S));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ACCESS;
          if (grant_d) begin
            owner_d = GNT_D;
            addr_d  = d_addr[ADDR_W+1:2];
            we_d    = d_we;
            wdata_d = d_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != MAX_S) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            owner_d  = GNT_IF;
            addr_d   = if_addr[ADDR_W+1:2];
            we_d     = 1'b0;
            wdata_d  = '0;
            streak_d = '0;
          end
        end
      end
      ACCESS: begin
        cnt_d   = LAT_C;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ONE_C) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == GNT_D) d_rdata_d  = mem_rdata;
            else                  if_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= GNT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      streak_q   <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state_q == RESP) && (owner_q == GNT_IF);
  assign d_done    = (state_q == RESP) && (owner_q == GNT_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (LAT 1,2,3,5), each with its own memory, a
// transaction-level reference model, directed scenarios and a randomized requester phase.
module tb_mem_arbiter;

  localparam int MS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [LAT=%0d] %s: got %h, expected %h (t=%0t)", lat, nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;

    logic        rst, if_req, d_req, d_we;
    logic        if_done, d_done, mem_en, mem_we, busy;
    logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic        pre_en;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] pipe    [0:L-1];
    bit          fin = 1'b0;
    int          ord[$];
    int          exp_ord[6];

    mem_arbiter #(.LAT(L), .ADDR_W(10), .MAX_STREAK(MS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory: write commits on the strobe edge, read data valid L cycles after the strobe, noise otherwise.
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (pre_en) mem[pre_addr] <= pre_data;
    end
    assign mem_rdata = pipe[L-1];

    // Reference model: a granted transaction occupies offsets 1..L+2 after its grant edge.
    bit          armed = 1'b0;
    bit          m_rst_prev, m_busy, m_own, m_we;
    int          m_t, m_streak;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_if_rd, m_d_rd;
    logic        m_gd;
    assign m_gd = d_req && !(if_req && (m_streak == MS));

    always @(posedge clk) begin
      armed      <= armed | !rst;
      m_rst_prev <= !rst;
      if (pre_en) ref_mem[pre_addr] <= pre_data;
      if (!rst) begin
        m_busy <= 1'b0; m_t <= 0; m_streak <= 0; m_if_rd <= '0; m_d_rd <= '0;
      end else if (!m_busy) begin
        if (if_req || d_req) begin
          m_busy   <= 1'b1;
          m_t      <= 1;
          m_own    <= m_gd;
          m_we     <= m_gd && d_we;
          m_wdata  <= d_wdata;
          m_addr   <= m_gd ? d_addr[11:2] : if_addr[11:2];
          m_streak <= (m_gd && if_req) ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
          if (m_gd && d_we) ref_mem[d_addr[11:2]] <= d_wdata;
        end
      end else begin
        m_t <= m_t + 1;
        if (m_t == L + 1 && !m_we) begin
          if (m_own) m_d_rd  <= ref_mem[m_addr];
          else       m_if_rd <= ref_mem[m_addr];
        end
        if (m_t == L + 2) m_busy <= 1'b0;
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        chk("busy",     L, 32'(busy),    32'(m_busy));
        chk("mem_en",   L, 32'(mem_en),  32'(m_busy && m_t == 1));
        chk("mem_we",   L, 32'(mem_we),  32'(m_busy && m_t == 1 && m_we));
        chk("if_done",  L, 32'(if_done), 32'(m_busy && m_t == L + 2 && !m_own));
        chk("d_done",   L, 32'(d_done),  32'(m_busy && m_t == L + 2 && m_own));
        chk("if_rdata", L, if_rdata, m_if_rd);
        chk("d_rdata",  L, d_rdata,  m_d_rd);
        if (m_busy && m_t == 1) chk("mem_addr", L, 32'(mem_addr), 32'(m_addr));
        if (m_busy && m_t == 1 && m_we) chk("mem_wdata", L, mem_wdata, m_wdata);
        if (m_rst_prev) begin
          chk("rst_mem_addr",  L, 32'(mem_addr), 32'd0);
          chk("rst_mem_wdata", L, mem_wdata, 32'd0);
        end
      end
    end

    initial begin
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      exp_ord = '{1, 1, 1, 1, 0, 1};
      for (int i = 0; i < 32; i++) begin
        tick(1);
        pre_en = 1'b1; pre_addr = 10'(i);
        pre_data = (i == 4) ? 32'h0050_0093 : $urandom;
      end
      tick(1);
      pre_en = 1'b0;
      chk("reset_busy",   L, 32'(busy),   32'd0);
      chk("reset_mem_en", L, 32'(mem_en), 32'd0);
      chk("reset_d_rdata", L, d_rdata, 32'd0);
      rst = 1'b1;

      // Single fetch.
      tick(1); if_req = 1'b1; if_addr = 32'h10;
      tick(1);
      chk("fetch_en",   L, 32'(mem_en),   32'd1);
      chk("fetch_addr", L, 32'(mem_addr), 32'd4);
      tick(L);
      chk("fetch_early", L, 32'(if_done), 32'd0);
      tick(1);
      chk("fetch_done", L, 32'(if_done), 32'd1);
      chk("fetch_data", L, if_rdata, 32'h0050_0093);
      if_req = 1'b0;

      // Store then load to the same word; store inputs change during ACCESS and must be ignored.
      tick(1); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      tick(1);
      chk("store_en",    L, 32'(mem_en),   32'd1);
      chk("store_we",    L, 32'(mem_we),   32'd1);
      chk("store_addr",  L, 32'(mem_addr), 32'd8);
      chk("store_wdata", L, mem_wdata, 32'hDEAD_BEEF);
      d_addr = 32'h3C; d_wdata = 32'h0;
      tick(L + 1);
      chk("store_done",  L, 32'(d_done), 32'd1);
      chk("store_rdata", L, d_rdata, 32'd0);
      d_we = 1'b0; d_addr = 32'h21;
      tick(2);
      chk("load_en",   L, 32'(mem_en),   32'd1);
      chk("load_we",   L, 32'(mem_we),   32'd0);
      chk("load_addr", L, 32'(mem_addr), 32'd8);
      tick(L + 1);
      chk("load_done", L, 32'(d_done), 32'd1);
      chk("load_data", L, d_rdata, 32'hDEAD_BEEF);
      d_req = 1'b0;

      // Contention with both requests held: D,D,D,D,IF,D.
      tick(1); if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
      for (int c = 0; c < 8 * (L + 3) + 10 && ord.size() < 6; c++) begin
        tick(1);
        if (if_done || d_done) begin
          chk("single_done", L, 32'(if_done & d_done), 32'd0);
          ord.push_back(d_done ? 1 : 0);
        end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("contention_count", L, 32'(ord.size()), 32'd6);
      for (int i = 0; i < 6; i++)
        chk("grant_order", L, (i < ord.size()) ? 32'(ord[i]) : 32'd9, 32'(exp_ord[i]));

      // Data request withdrawn during WAIT; the pending fetch follows.
      tick(1); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; if_req = 1'b1; if_addr = 32'h20;
      tick(1);
      chk("wd_addr", L, 32'(mem_addr), 32'd4);
      tick(1); d_req = 1'b0;
      tick(L);
      chk("wd_done", L, 32'(d_done), 32'd1);
      chk("wd_data", L, d_rdata, 32'h0050_0093);
      tick(2);
      chk("wd_fetch_en",   L, 32'(mem_en),   32'd1);
      chk("wd_fetch_addr", L, 32'(mem_addr), 32'd8);
      tick(L + 1);
      chk("wd_fetch_done", L, 32'(if_done), 32'd1);
      chk("wd_fetch_data", L, if_rdata, 32'hDEAD_BEEF);
      if_req = 1'b0;

      // Reset during WAIT aborts the load.
      tick(1); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
      tick(2); rst = 1'b0;
      tick(1);
      chk("rr_busy",   L, 32'(busy),     32'd0);
      chk("rr_en",     L, 32'(mem_en),   32'd0);
      chk("rr_done",   L, 32'(d_done),   32'd0);
      chk("rr_drdata", L, d_rdata,       32'd0);
      chk("rr_irdata", L, if_rdata,      32'd0);
      chk("rr_addr",   L, 32'(mem_addr), 32'd0);
      rst = 1'b1; d_req = 1'b0;
      for (int i = 0; i < L + 3; i++) begin
        tick(1);
        chk("rr_no_done", L, 32'(d_done | if_done), 32'd0);
      end
      if_req = 1'b1; if_addr = 32'h10;
      tick(L + 2);
      chk("rr_fetch_done", L, 32'(if_done), 32'd1);
      chk("rr_fetch_data", L, if_rdata, 32'h0050_0093);
      if_req = 1'b0;

      // Randomized requesters obeying the hold-until-done rule, with withdrawals and rare resets.
      for (int k = 0; k < 2500; k++) begin
        tick(1);
        rst = ($urandom_range(0, 299) != 0);
        if (if_req && if_done)   if_req = 1'($urandom_range(0, 1));
        else if (if_req)         begin if ($urandom_range(0, 15) == 0) if_req = 1'b0; end
        else                     if_req = 1'($urandom_range(0, 1));
        if (d_req && d_done)     d_req = 1'($urandom_range(0, 1));
        else if (d_req)          begin if ($urandom_range(0, 15) == 0) d_req = 1'b0; end
        else                     d_req = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) if_addr = $urandom & 32'hFFFF_F03F;
        if ($urandom_range(0, 3) == 0) begin
          d_addr  = $urandom & 32'hFFFF_F03F;
          d_we    = 1'($urandom_range(0, 1));
          d_wdata = $urandom;
        end
      end
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
      tick(L + 5);
      fin = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000; c++) begin
      if (inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin) break;
      @(posedge clk);
    end
    if (!(inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin)) begin
      n_tests++;
      n_fail++;
      $display("FAIL completion: stimulus did not finish within 20000 cycles");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
